// File: rtl/display_pkg.sv
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared types and elaboration helpers for the display PWM decoder.
//            DISPLAY_PWM_STAGGER_EN selects staggered per-channel phase offsets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

`ifdef DISPLAY_PWM_STAGGER_EN
    localparam int c_stagger_en = 1;
`else
    localparam int c_stagger_en = 0;
`endif

    // PWM period in ticks; the all-ones value therefore means "always on".
    function automatic int period_of(input int cyclewidth);
        return (1 << cyclewidth) - 1;
    endfunction

    // Phase offset of one channel; zero for every channel when stagger is off.
    function automatic int offset_of(input int channel, input int period, input int nchannels);
        return ((channel * period) / nchannels) * c_stagger_en;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_pwm_channel.sv
// ============================================================================
// Module   : display_pwm_channel
// Purpose  : One PWM channel: phase offset with wrap, compare, output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_pwm_channel
    import display_pkg::*;
#(
    parameter int cyclewidth = 8,
    parameter int offset     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_run,
    input  logic [cyclewidth-1:0] i_count,
    input  logic [cyclewidth-1:0] i_value,
    output logic                  o_out
);

    localparam logic [cyclewidth:0] c_period = (cyclewidth + 1)'(period_of(cyclewidth));
    localparam logic [cyclewidth:0] c_offset = (cyclewidth + 1)'(offset);

    logic [cyclewidth:0]   w_sum;
    logic [cyclewidth-1:0] w_phase;
    logic                  r_out;

    // Counter and offset are both below the period, so one subtraction wraps.
    always_comb begin
        w_sum   = {1'b0, i_count} + c_offset;
        w_phase = (w_sum >= c_period) ? cyclewidth'(w_sum - c_period)
                                      : w_sum[cyclewidth-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= i_run && (i_value > w_phase);
        end
    end

    assign o_out = r_out;

endmodule

`default_nettype wire

// File: rtl/display_pwm_decoder.sv
// ============================================================================
// Module   : display_pwm_decoder
// Purpose  : Double-buffered per-channel PWM generator for LED column drivers.
//            Define DISPLAY_PWM_STAGGER_EN to stagger channel phase offsets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_pwm_decoder
    import display_pkg::*;
#(
    parameter int segments   = 1,
    parameter int cyclewidth = 8,
    parameter int prescale   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable,
    input  logic [cyclewidth*3*segments-1:0] cpixel,
    input  logic                             cpixel_valid,
    output logic                             cpixel_ready,
    output logic [3*segments-1:0]            out,
    output logic                             period_start
);

    localparam int c_nch    = 3 * segments;
    localparam int c_width  = cyclewidth * c_nch;
    localparam int c_period = period_of(cyclewidth);
    localparam int c_pw     = (prescale > 1) ? $clog2(prescale) : 1;

    localparam logic [cyclewidth-1:0] c_count_max = cyclewidth'(c_period - 1);
    localparam logic [c_pw-1:0]       c_presc_max = c_pw'(prescale - 1);

    state_t                r_state;
    logic [c_pw-1:0]       r_presc;
    logic [cyclewidth-1:0] r_count;
    logic [c_width-1:0]    r_active;
    logic [c_width-1:0]    r_pending;
    logic                  r_pend_full;
    logic                  r_period_start;

    logic w_tick;
    logic w_run;
    logic w_boundary;
    logic w_accept;

    assign cpixel_ready = !r_pend_full && !rst;
    assign period_start = r_period_start;

    always_comb begin
        w_tick     = (r_presc == c_presc_max);
        w_run      = (r_state == RUN) && enable;
        w_boundary = ((r_state == IDLE) && enable)
                  || (w_run && w_tick && (r_count == c_count_max));
        w_accept   = cpixel_valid && cpixel_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_presc        <= '0;
            r_count        <= '0;
            r_active       <= '0;
            r_pending      <= '0;
            r_pend_full    <= 1'b0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_boundary;

            if (!enable) begin
                r_state <= IDLE;
                r_presc <= '0;
                r_count <= '0;
            end else if (w_boundary) begin
                r_state <= RUN;
                r_presc <= '0;
                r_count <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_count <= r_count + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // A held pending word always wins the boundary over a fresh input.
            if (w_boundary) begin
                if (r_pend_full) begin
                    r_active    <= r_pending;
                    r_pend_full <= 1'b0;
                end else if (cpixel_valid) begin
                    r_active <= cpixel;
                end
            end else if (w_accept) begin
                r_pending   <= cpixel;
                r_pend_full <= 1'b1;
            end
        end
    end

    generate
        for (genvar c = 0; c < c_nch; c++) begin : g_channel
            display_pwm_channel #(
                .cyclewidth (cyclewidth),
                .offset     (offset_of(c, c_period, c_nch))
            ) u_channel (
                .clk     (clk),
                .rst     (rst),
                .i_run   (w_run),
                .i_count (r_count),
                .i_value (r_active[c*cyclewidth +: cyclewidth]),
                .o_out   (out[c])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_display_pwm_decoder.sv
// ============================================================================
// Module   : tb_display_pwm_decoder
// Purpose  : Self-checking bench for display_pwm_decoder (cyclewidth 4, P = 15).
//            Honours DISPLAY_PWM_STAGGER_EN in its reference offsets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_pwm_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [11:0] cpixel = '0;
    logic        cpixel_valid = 1'b0;
    logic        cpixel_ready;
    logic [2:0]  out;
    logic        period_start;

    logic        enable3 = 1'b0;
    logic [11:0] cpixel3 = '0;
    logic        valid3 = 1'b0;
    logic        ready3;
    logic [2:0]  out3;
    logic        ps3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    display_pwm_decoder #(.segments(1), .cyclewidth(4), .prescale(1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cpixel(cpixel),
        .cpixel_valid(cpixel_valid), .cpixel_ready(cpixel_ready),
        .out(out), .period_start(period_start)
    );

    display_pwm_decoder #(.segments(1), .cyclewidth(4), .prescale(3)) dut3 (
        .clk(clk), .rst(rst), .enable(enable3), .cpixel(cpixel3),
        .cpixel_valid(valid3), .cpixel_ready(ready3),
        .out(out3), .period_start(ps3)
    );

    // Reference: channel c is on while value > (tick + offset) mod 15.
    function automatic int model_off(input int c);
`ifdef DISPLAY_PWM_STAGGER_EN
        return (c * 15) / 3;
`else
        return c * 0;
`endif
    endfunction

    function automatic logic [2:0] model_out(input logic [11:0] word, input int tick);
        logic [2:0] r;
        int v;
        for (int c = 0; c < 3; c++) begin
            v = int'(word[c*4 +: 4]);
            r[c] = v > (((tick % 15) + model_off(c)) % 15);
        end
        return r;
    endfunction

    function automatic logic [11:0] mkword(input int a, input int b, input int c);
        return {4'(c), 4'(b), 4'(a)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ps(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            step();
            ok = period_start;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        checks++; if (out !== 3'b000) begin errors++; $display("FAIL reset_out got=%b exp=000", out); end
        checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_ps got=%b exp=0", period_start); end
        checks++; if (cpixel_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cpixel_ready); end
        checks++; if ({out3, ps3, ready3} !== 5'b0) begin errors++; $display("FAIL reset_dut3 got=%b exp=00000", {out3, ps3, ready3}); end
        rst = 1'b0;
        #1;
        checks++; if (cpixel_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", cpixel_ready); end
    endtask

    task automatic test_duty();
        logic [11:0] w;
        int highs [3][3];
        w = mkword(0, 15, 5);
        highs = '{default: 0};
        step();
        cpixel = w; cpixel_valid = 1'b1;
        step();
        cpixel_valid = 1'b0;
        checks++; if (cpixel_ready !== 1'b0) begin errors++; $display("FAIL duty_preload_ready got=%b exp=0", cpixel_ready); end
        enable = 1'b1;
        step();
        checks++; if (period_start !== 1'b1 || out !== 3'b000) begin errors++; $display("FAIL duty_start ps=%b out=%b exp ps=1 out=000", period_start, out); end
        for (int k = 1; k <= 45; k++) begin
            step();
            checks++; if (out !== model_out(w, k - 1)) begin errors++; $display("FAIL duty_out k=%0d got=%b exp=%b", k, out, model_out(w, k - 1)); end
            checks++; if (period_start !== (k % 15 == 0)) begin errors++; $display("FAIL duty_ps k=%0d got=%b", k, period_start); end
            for (int c = 0; c < 3; c++) highs[(k - 1) / 15][c] += int'(out[c]);
        end
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 3; c++) begin
                checks++; if (highs[p][c] != int'(w[c*4 +: 4])) begin errors++; $display("FAIL duty_count p=%0d ch=%0d got=%0d exp=%0d", p, c, highs[p][c], w[c*4 +: 4]); end
            end
        checks++; if (cpixel_ready !== 1'b1) begin errors++; $display("FAIL duty_ready_after got=%b exp=1", cpixel_ready); end
    endtask

    task automatic test_back_to_back(input logic [11:0] a, output logic [11:0] last);
        logic [11:0] words [3];
        logic [11:0] exp;
        bit ok;
        words[0] = a; words[1] = 12'($urandom); words[2] = 12'($urandom);
        wait_ps(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_wait_ps got=timeout exp=pulse"); end
        for (int k = 1; k <= 45; k++) begin
            step();
            exp = model_out(words[(k - 1) / 15], (k - 1) % 15);
            checks++; if (out !== exp) begin errors++; $display("FAIL b2b_out k=%0d got=%b exp=%b", k, out, exp); end
            if (k == 3) begin
                checks++; if (cpixel_ready !== 1'b1) begin errors++; $display("FAIL b2b_first_ready got=%b exp=1", cpixel_ready); end
                cpixel = words[1]; cpixel_valid = 1'b1;
            end else if (k >= 4 && k <= 14) begin
                checks++; if (cpixel_ready !== 1'b0) begin errors++; $display("FAIL b2b_blocked k=%0d got=%b exp=0", k, cpixel_ready); end
                cpixel = words[2];
            end else if (k == 15) begin
                checks++; if (period_start !== 1'b1 || cpixel_ready !== 1'b1) begin errors++; $display("FAIL b2b_boundary ps=%b ready=%b exp=1,1", period_start, cpixel_ready); end
            end else if (k == 16) begin
                checks++; if (cpixel_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_taken got=%b exp=0", cpixel_ready); end
                cpixel_valid = 1'b0;
            end else if (k == 30) begin
                checks++; if (cpixel_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_loaded got=%b exp=1", cpixel_ready); end
            end
        end
        last = words[2];
    endtask

    task automatic test_enable_drop(input logic [11:0] cur, output logic [11:0] last);
        logic [11:0] d;
        int highs [3];
        bit ok;
        d = 12'($urandom);
        highs = '{default: 0};
        wait_ps(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_wait_ps got=timeout exp=pulse"); end
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++; if (out !== model_out(cur, k - 1)) begin errors++; $display("FAIL drop_pre_out k=%0d got=%b exp=%b", k, out, model_out(cur, k - 1)); end
            if (k == 2) begin cpixel = d; cpixel_valid = 1'b1; end
            if (k == 3) cpixel_valid = 1'b0;
        end
        enable = 1'b0;
        step();
        checks++; if (out !== 3'b000 || period_start !== 1'b0) begin errors++; $display("FAIL drop_out out=%b ps=%b exp out=000 ps=0", out, period_start); end
        checks++; if (cpixel_ready !== 1'b0) begin errors++; $display("FAIL drop_pending_kept got=%b exp=0", cpixel_ready); end
        repeat (3) step();
        checks++; if (out !== 3'b000) begin errors++; $display("FAIL drop_idle_out got=%b exp=000", out); end
        enable = 1'b1;
        step();
        checks++; if (period_start !== 1'b1 || out !== 3'b000) begin errors++; $display("FAIL drop_reenable ps=%b out=%b exp ps=1 out=000", period_start, out); end
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++; if (out !== model_out(d, k - 1)) begin errors++; $display("FAIL drop_post_out k=%0d got=%b exp=%b", k, out, model_out(d, k - 1)); end
            for (int c = 0; c < 3; c++) highs[c] += int'(out[c]);
        end
        for (int c = 0; c < 3; c++) begin
            checks++; if (highs[c] != int'(d[c*4 +: 4])) begin errors++; $display("FAIL drop_count ch=%0d got=%0d exp=%0d", c, highs[c], d[c*4 +: 4]); end
        end
        checks++; if (cpixel_ready !== 1'b1) begin errors++; $display("FAIL drop_ready_after got=%b exp=1", cpixel_ready); end
        last = d;
    endtask

    task automatic test_stagger(input logic [11:0] cur);
        logic [11:0] s;
        logic [11:0] exp_w;
        int first [3];
        int exp_first;
        bit ok;
        s = mkword(5, 5, 5);
        first = '{default: 0};
        wait_ps(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stag_wait_ps got=timeout exp=pulse"); end
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_w = (k <= 15) ? cur : s;
            checks++; if (out !== model_out(exp_w, k - 1)) begin errors++; $display("FAIL stag_out k=%0d got=%b exp=%b", k, out, model_out(exp_w, k - 1)); end
            if (k == 2) begin cpixel = s; cpixel_valid = 1'b1; end
            if (k == 3) cpixel_valid = 1'b0;
            for (int c = 0; c < 3; c++)
                if (k > 15 && first[c] == 0 && out[c]) first[c] = k - 15;
        end
        for (int c = 0; c < 3; c++) begin
            exp_first = ((15 - model_off(c)) % 15) + 1;
            checks++; if (first[c] != exp_first) begin errors++; $display("FAIL stag_rise ch=%0d got=%0d exp=%0d", c, first[c], exp_first); end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        bit ok;
        e = 12'($urandom) | 12'h111;
        wait_ps(40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_wait_ps got=timeout exp=pulse"); end
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 2) begin cpixel = e; cpixel_valid = 1'b1; end
            if (k == 3) cpixel_valid = 1'b0;
        end
        checks++; if (cpixel_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pending_full got=%b exp=0", cpixel_ready); end
        rst = 1'b1;
        step();
        checks++; if (out !== 3'b000 || period_start !== 1'b0 || cpixel_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_reset out=%b ps=%b ready=%b exp 000,0,0", out, period_start, cpixel_ready); end
        rst = 1'b0;
        #1;
        checks++; if (cpixel_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", cpixel_ready); end
        step();
        checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL rstmid_restart got=%b exp=1", period_start); end
        for (int k = 1; k <= 15; k++) begin
            step();
            checks++; if (out !== 3'b000) begin errors++; $display("FAIL rstmid_active_zero k=%0d got=%b exp=000", k, out); end
        end
    endtask

    task automatic test_prescale3();
        logic [11:0] w;
        int highs [2][3];
        w = mkword(5, int'($urandom_range(0, 15)), 15);
        highs = '{default: 0};
        step();
        cpixel3 = w; valid3 = 1'b1;
        step();
        valid3 = 1'b0; enable3 = 1'b1;
        step();
        checks++; if (ps3 !== 1'b1 || out3 !== 3'b000) begin errors++; $display("FAIL pre3_start ps=%b out=%b exp ps=1 out=000", ps3, out3); end
        for (int k = 1; k <= 90; k++) begin
            step();
            checks++; if (out3 !== model_out(w, (k - 1) / 3)) begin errors++; $display("FAIL pre3_out k=%0d got=%b exp=%b", k, out3, model_out(w, (k - 1) / 3)); end
            checks++; if (ps3 !== (k % 45 == 0)) begin errors++; $display("FAIL pre3_ps k=%0d got=%b", k, ps3); end
            for (int c = 0; c < 3; c++) highs[(k - 1) / 45][c] += int'(out3[c]);
        end
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 3; c++) begin
                checks++; if (highs[p][c] != 3 * int'(w[c*4 +: 4])) begin errors++; $display("FAIL pre3_count p=%0d ch=%0d got=%0d exp=%0d", p, c, highs[p][c], 3 * w[c*4 +: 4]); end
            end
    endtask

    initial begin
        logic [11:0] cur;
        test_reset();
        test_duty();
        test_back_to_back(mkword(0, 15, 5), cur);
        test_enable_drop(cur, cur);
        test_stagger(cur);
        test_reset_mid();
        test_prescale3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
